// File: rtl/arbitro_alu.sv
// arbitro_alu: round-robin two-requester sequencer sharing one combinational ALU
module arbitro_alu #(
  parameter int N = 32,
  parameter int CICLOS_EJEC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sol0_valido,
  input  logic [N-1:0] sol0_A,
  input  logic [N-1:0] sol0_B,
  input  logic [2:0]   sol0_Sel,
  output logic         sol0_listo,
  input  logic         sol1_valido,
  input  logic [N-1:0] sol1_A,
  input  logic [N-1:0] sol1_B,
  input  logic [2:0]   sol1_Sel,
  output logic         sol1_listo,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [2:0]   alu_Sel,
  input  logic [N-1:0] alu_C,
  input  logic         alu_banNegativo,
  input  logic         alu_banCero,
  input  logic         alu_banDesborde,
  input  logic         alu_banAcarreo,
  output logic         res_valido,
  input  logic         res_listo,
  output logic [N-1:0] res_C,
  output logic [3:0]   res_banderas,
  output logic         res_id,
  output logic         ocupado
);
  localparam int CW = $clog2(CICLOS_EJEC + 1);
  typedef enum logic [1:0] {REPOSO, EJECUTA, RESPONDE} estado_t;
  estado_t estado, estado_sig;
  logic ultimo, grant, alguno, acepta;
  logic [CW-1:0] cnt;
  // the requester that did not win last time has priority when both ask
  assign grant = (sol0_valido & sol1_valido) ? ~ultimo : sol1_valido;
  assign alguno = sol0_valido | sol1_valido;
  assign sol0_listo = (estado == REPOSO) & alguno & ~grant;
  assign sol1_listo = (estado == REPOSO) & alguno & grant;
  assign acepta = sol0_listo | sol1_listo;
  assign res_valido = estado == RESPONDE;
  assign ocupado = estado != REPOSO;
  always_comb begin
    estado_sig = estado;
    estado_sig = (estado == REPOSO) ? (acepta ? EJECUTA : REPOSO) :
                 (estado == EJECUTA) ? ((cnt == '0) ? RESPONDE : EJECUTA) :
                 (res_listo ? REPOSO : RESPONDE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) estado <= REPOSO;
    else estado <= estado_sig;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ultimo       <= 1'b1;
      cnt          <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_Sel      <= '0;
      res_C        <= '0;
      res_banderas <= '0;
      res_id       <= 1'b0;
    end else begin
      if (acepta) begin
        alu_A   <= grant ? sol1_A : sol0_A;
        alu_B   <= grant ? sol1_B : sol0_B;
        alu_Sel <= grant ? sol1_Sel : sol0_Sel;
        ultimo  <= grant;
        cnt     <= CW'(CICLOS_EJEC - 1);
      end
      if (estado == EJECUTA && cnt != '0) cnt <= cnt - CW'(1);
      if (estado == EJECUTA && cnt == '0) begin
        res_C        <= alu_C;
        res_banderas <= {alu_banNegativo, alu_banCero, alu_banDesborde, alu_banAcarreo};
        res_id       <= ultimo;
      end
    end
  end
endmodule

// File: tb/tb_arbitro_alu.sv
// tb_arbitro_alu: table-driven and scoreboard bench for arbitro_alu (CICLOS_EJEC 1 and 4)
module tb_arbitro_alu;
  logic clk = 1'b0, rst = 1'b1;
  logic sol0_valido = 1'b0, sol1_valido = 1'b0, res_listo = 1'b1;
  logic [31:0] sol0_A = '0, sol0_B = '0, sol1_A = '0, sol1_B = '0;
  logic [2:0] sol0_Sel = '0, sol1_Sel = '0;
  logic sol0_listo, sol1_listo, l4_0, l4_1;
  logic [31:0] a1_A, a1_B, a1_C, res1_C, alu4_A, alu4_B, res4_C;
  logic [31:0] alu4_c = '0;
  logic [2:0] a1_Sel, alu4_Sel;
  logic a1_n, a1_z, a1_v, a1_k;
  logic [32:0] s1;
  logic res1_valido, res1_id, ocup1, res4_valido, res4_id, ocup4;
  logic [3:0] res1_ban, res4_ban;
  int tests = 0, fails = 0, cyc = 0;

  typedef struct {logic id; logic [31:0] c; logic [3:0] ban;} exp_t;
  typedef struct {logic id; logic [31:0] a; logic [31:0] b; logic [2:0] sel; logic [31:0] c; logic [3:0] ban;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in ALU: add, sub, and, or, xor, otherwise pass A
  always_comb begin
    s1 = {1'b0, a1_A} + {1'b0, a1_B};
    a1_C = a1_Sel == 3'd0 ? s1[31:0] : a1_Sel == 3'd1 ? a1_A - a1_B :
           a1_Sel == 3'd2 ? a1_A & a1_B : a1_Sel == 3'd3 ? a1_A | a1_B :
           a1_Sel == 3'd4 ? a1_A ^ a1_B : a1_A;
    a1_n = a1_C[31];
    a1_z = a1_C == 32'd0;
    a1_v = a1_Sel == 3'd0 && a1_A[31] == a1_B[31] && a1_C[31] != a1_A[31];
    a1_k = a1_Sel == 3'd0 && s1[32];
  end

  arbitro_alu #(.N(32), .CICLOS_EJEC(1)) dut (
    .clk(clk), .rst(rst),
    .sol0_valido(sol0_valido), .sol0_A(sol0_A), .sol0_B(sol0_B), .sol0_Sel(sol0_Sel), .sol0_listo(sol0_listo),
    .sol1_valido(sol1_valido), .sol1_A(sol1_A), .sol1_B(sol1_B), .sol1_Sel(sol1_Sel), .sol1_listo(sol1_listo),
    .alu_A(a1_A), .alu_B(a1_B), .alu_Sel(a1_Sel), .alu_C(a1_C),
    .alu_banNegativo(a1_n), .alu_banCero(a1_z), .alu_banDesborde(a1_v), .alu_banAcarreo(a1_k),
    .res_valido(res1_valido), .res_listo(res_listo), .res_C(res1_C), .res_banderas(res1_ban),
    .res_id(res1_id), .ocupado(ocup1));

  arbitro_alu #(.N(32), .CICLOS_EJEC(4)) dut4 (
    .clk(clk), .rst(rst),
    .sol0_valido(sol0_valido), .sol0_A(sol0_A), .sol0_B(sol0_B), .sol0_Sel(sol0_Sel), .sol0_listo(l4_0),
    .sol1_valido(sol1_valido), .sol1_A(sol1_A), .sol1_B(sol1_B), .sol1_Sel(sol1_Sel), .sol1_listo(l4_1),
    .alu_A(alu4_A), .alu_B(alu4_B), .alu_Sel(alu4_Sel), .alu_C(alu4_c),
    .alu_banNegativo(1'b1), .alu_banCero(1'b0), .alu_banDesborde(1'b0), .alu_banAcarreo(1'b1),
    .res_valido(res4_valido), .res_listo(res_listo), .res_C(res4_C), .res_banderas(res4_ban),
    .res_id(res4_id), .ocupado(ocup4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] c, input logic [3:0] ban);
    exp_t e;
    e.id = id; e.c = c; e.ban = ban;
    sb.push_back(e);
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                       input bit do_push, input logic [31:0] ec, input logic [3:0] eb, output int waits);
    @(posedge clk); #1;
    if (id) begin sol1_valido = 1'b1; sol1_A = a; sol1_B = b; sol1_Sel = sel; end
    else begin sol0_valido = 1'b1; sol0_A = a; sol0_B = b; sol0_Sel = sel; end
    waits = 0;
    @(negedge clk);
    while (!(id ? sol1_listo : sol0_listo) && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_timeout", 32'(waits < 50), 32'd1);
    if (waits < 50 && do_push) push(id, ec, eb);
    @(posedge clk); #1;
    sol0_valido = 1'b0; sol1_valido = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) if (!rst) begin
    chk("both_listo", 32'(sol0_listo & sol1_listo), 32'd0);
    chk("both_listo4", 32'(l4_0 & l4_1), 32'd0);
    if (res1_valido && res_listo) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got id=%0d c=%h, expected none", res1_id, res1_C);
      end else begin
        mon_e = sb.pop_front();
        chk("res_C", res1_C, mon_e.c);
        chk("res_banderas", 32'(res1_ban), 32'(mon_e.ban));
        chk("res_id", 32'(res1_id), 32'(mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, n;
    int ids[4];
    int cy[4];
    tbl[0] = '{1'b0, 32'd5, 32'd3, 3'd0, 32'd8, 4'b0000};
    tbl[1] = '{1'b1, 32'd7, 32'd7, 3'd1, 32'd0, 4'b0100};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'd1, 3'd0, 32'd0, 4'b0101};
    tbl[3] = '{1'b1, 32'h7FFFFFFF, 32'd1, 3'd0, 32'h80000000, 4'b1010};
    tbl[4] = '{1'b0, 32'd3, 32'd5, 3'd1, 32'hFFFFFFFE, 4'b1000};
    tbl[5] = '{1'b1, 32'hF0F0, 32'hFF00, 3'd2, 32'hF000, 4'b0000};
    tbl[6] = '{1'b0, 32'h0F, 32'hF0, 3'd3, 32'hFF, 4'b0000};
    tbl[7] = '{1'b1, 32'h12345678, 32'd0, 3'd7, 32'h12345678, 4'b0000};
    repeat (2) @(negedge clk);
    chk("rst_ocupado", 32'(ocup1), 32'd0);
    chk("rst_res_valido", 32'(res1_valido), 32'd0);
    chk("rst_res_C", res1_C, 32'd0);
    chk("rst_res_ban", 32'(res1_ban), 32'd0);
    chk("rst_res_id", 32'(res1_id), 32'd0);
    chk("rst_alu_A", a1_A, 32'd0);
    chk("rst_alu_B", a1_B, 32'd0);
    chk("rst_alu_Sel", 32'(a1_Sel), 32'd0);
    chk("rst_ocupado4", 32'(ocup4), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (tbl[i]) begin
      issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sel, 1'b1, tbl[i].c, tbl[i].ban, w);
      chk("listo_first_cycle", 32'(w), 32'd0);
      drain();
    end
    // latency: one cycle of EJECUTA, then result
    issue(1'b1, 32'd1, 32'd2, 3'd0, 1'b1, 32'd3, 4'b0000, w);
    @(negedge clk);
    chk("lat_ejecuta_valido", 32'(res1_valido), 32'd0);
    chk("lat_ejecuta_ocupado", 32'(ocup1), 32'd1);
    @(negedge clk);
    chk("lat_responde_valido", 32'(res1_valido), 32'd1);
    drain();
    // fairness with both requesters asking continuously
    @(posedge clk); #1;
    sol0_A = 32'd10; sol0_B = 32'd1; sol0_Sel = 3'd0; sol0_valido = 1'b1;
    sol1_A = 32'd20; sol1_B = 32'd2; sol1_Sel = 3'd0; sol1_valido = 1'b1;
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (sol0_listo | sol1_listo) begin
        ids[n] = int'(sol1_listo);
        cy[n] = cyc;
        if (sol1_listo) push(1'b1, 32'd22, 4'b0000);
        else push(1'b0, 32'd11, 4'b0000);
        n++;
      end
    end
    @(posedge clk); #1 sol0_valido = 1'b0; sol1_valido = 1'b0;
    chk("fair_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      chk("fair_order", 32'(ids[i]), 32'(i % 2));
      if (i > 0) chk("fair_gap", 32'(cy[i] - cy[i-1]), 32'd3);
    end
    drain();
    // back-pressure
    @(posedge clk); #1 res_listo = 1'b0;
    issue(1'b0, 32'd100, 32'd1, 3'd0, 1'b1, 32'd101, 4'b0000, w);
    sol0_A = 32'd200; sol0_B = 32'd2; sol0_Sel = 3'd0; sol0_valido = 1'b1;
    n = 0;
    @(negedge clk);
    while (!res1_valido && n < 20) begin n++; @(negedge clk); end
    chk("bp_res_valido", 32'(res1_valido), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_C", res1_C, 32'd101);
      chk("bp_res_id", 32'(res1_id), 32'd0);
      chk("bp_ocupado", 32'(ocup1), 32'd1);
      chk("bp_sol0_listo", 32'(sol0_listo), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 res_listo = 1'b1;
    @(negedge clk);
    chk("bp_release_listo_low", 32'(sol0_listo), 32'd0);
    @(negedge clk);
    chk("bp_next_accept", 32'(sol0_listo), 32'd1);
    if (sol0_listo) push(1'b0, 32'd202, 4'b0000);
    @(posedge clk); #1 sol0_valido = 1'b0;
    drain();
    // CICLOS_EJEC=4: ALU output changes mid-execution, last value is captured
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    alu4_c = 32'd0;
    issue(1'b0, 32'h11, 32'h22, 3'd5, 1'b1, 32'h11, 4'b0000, w);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("stub_alu_A", alu4_A, 32'h11);
      chk("stub_alu_B", alu4_B, 32'h22);
      chk("stub_alu_Sel", 32'(alu4_Sel), 32'd5);
      chk("stub_res_valido_low", 32'(res4_valido), 32'd0);
      chk("stub_ocupado", 32'(ocup4), 32'd1);
      @(posedge clk); #1;
      if (j == 1) alu4_c = 32'hDEAD;
      if (j == 3) alu4_c = 32'hBEEF;
    end
    @(negedge clk);
    chk("stub_res_valido", 32'(res4_valido), 32'd1);
    chk("stub_res_C", res4_C, 32'hBEEF);
    chk("stub_res_ban", 32'(res4_ban), 32'b1001);
    chk("stub_res_id", 32'(res4_id), 32'd0);
    drain();
    // asynchronous reset in the middle of EJECUTA
    issue(1'b1, 32'd3, 32'd4, 3'd0, 1'b0, 32'd0, 4'b0000, w);
    #2 rst = 1'b1;
    #1;
    chk("arst_ocupado", 32'(ocup1), 32'd0);
    chk("arst_res_valido", 32'(res1_valido), 32'd0);
    chk("arst_ocupado4", 32'(ocup4), 32'd0);
    chk("arst_res_valido4", 32'(res4_valido), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_result", 32'(res1_valido), 32'd0);
      chk("arst_no_result4", 32'(res4_valido), 32'd0);
    end
    @(posedge clk); #1;
    sol0_A = 32'd9; sol0_B = 32'd9; sol0_Sel = 3'd0; sol0_valido = 1'b1;
    sol1_A = 32'd1; sol1_B = 32'd1; sol1_Sel = 3'd0; sol1_valido = 1'b1;
    @(negedge clk);
    chk("arst_first_grant0", 32'(sol0_listo), 32'd1);
    chk("arst_first_grant1", 32'(sol1_listo), 32'd0);
    if (sol0_listo) push(1'b0, 32'd18, 4'b0000);
    @(posedge clk); #1 sol0_valido = 1'b0; sol1_valido = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
